// File: rtl/adder_flit_injector.sv
// adder_flit_injector: packet/flit stimulus source for the adder's operand buses.
// Emits NUM_PKT packets of PAYLOAD flits, each followed by GAP idle cycles.
// Optional LFSR data generator is compiled in with `define INJECTOR_LFSR_EN;
// without it the toggle pattern is always used and pattern_sel is ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; outputs hold last flit
// S_SEND | one payload flit presented per cycle, valid=1
// S_GAP  | idle cycles after a packet; operands hold the last flit
// S_DONE | single-cycle done pulse, then back to S_IDLE

module adder_flit_injector #(
  parameter int N       = 12,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int NUM_PKT = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pattern_sel,
  output logic [N-1:0]  input1,
  output logic [N-1:0]  input2,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   flit_cnt,
  output logic [15:0]   pkt_cnt
);

  localparam int          W      = 2 * N;
  localparam logic [15:0] PAY_M1 = 16'(PAYLOAD - 1);
  localparam logic [15:0] GAP_M1 = (GAP > 0) ? 16'(GAP - 1) : 16'd0;
  localparam logic [15:0] PKT_M1 = 16'(NUM_PKT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  word_q, word_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   flit_cnt_q, flit_cnt_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  // Down-counters: flits left after the current one, packets left after
  // the current one, and gap cycles left after the current one.
  logic [15:0]   beat_left_q, beat_left_d;
  logic [15:0]   pkt_left_q, pkt_left_d;
  logic [15:0]   gap_left_q, gap_left_d;

  logic          last_flit, last_pkt, gap_done;
  logic          accept, load_first, load_next;
  logic [W-1:0]  toggle_word;

`ifdef INJECTOR_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE10001;
  logic          sel_q, sel_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [31:0]   lfsr_src, lfsr_adv;

  // Fibonacci LFSR, taps 32,22,2,1, shifting towards the MSB.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
`else
  logic          unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign last_flit = (beat_left_q == 16'd0);
  assign last_pkt  = (pkt_left_q == 16'd0);
  assign gap_done  = (gap_left_q == 16'd0);

  assign input1   = word_q[N-1:0];
  assign input2   = word_q[W-1:N];
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign flit_cnt = flit_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flit_cnt_q  <= 16'd0;
      pkt_cnt_q   <= 16'd0;
      beat_left_q <= 16'd0;
      pkt_left_q  <= 16'd0;
      gap_left_q  <= 16'd0;
`ifdef INJECTOR_LFSR_EN
      sel_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      flit_cnt_q  <= flit_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      beat_left_q <= beat_left_d;
      pkt_left_q  <= pkt_left_d;
      gap_left_q  <= gap_left_d;
`ifdef INJECTOR_LFSR_EN
      sel_q       <= sel_d;
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  // Next-state logic driven by the terminal counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEND;
      S_SEND: begin
        if (last_flit) begin
          if (GAP > 0)       state_d = S_GAP;
          else if (last_pkt) state_d = S_DONE;
        end
      end
      S_GAP:  if (gap_done) state_d = last_pkt ? S_DONE : S_SEND;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs follow the state being entered.
  always_comb begin
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_SEND) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  // Counters and flit word generation.
  always_comb begin
    accept      = (state_q == S_IDLE) && start;
    // A packet other than the first begins when SEND is (re)entered after a packet end.
    load_first  = accept ||
                  ((state_q == S_SEND) && last_flit && (state_d == S_SEND)) ||
                  ((state_q == S_GAP) && (state_d == S_SEND));
    load_next   = (state_q == S_SEND) && !last_flit;
    toggle_word = load_first ? {W{1'b1}} : ~word_q;

    word_d      = word_q;
    flit_cnt_d  = flit_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    beat_left_d = beat_left_q;
    pkt_left_d  = pkt_left_q;
    gap_left_d  = gap_left_q;

    if (accept) begin
      flit_cnt_d = 16'd0;
      pkt_cnt_d  = 16'd0;
      pkt_left_d = PKT_M1;
    end else if (load_first) begin
      pkt_left_d = pkt_left_q - 16'd1;
    end

    if (load_first)     beat_left_d = PAY_M1;
    else if (load_next) beat_left_d = beat_left_q - 16'd1;

    if ((state_q == S_SEND) && last_flit) begin
      pkt_cnt_d  = sat_inc(pkt_cnt_q);
      gap_left_d = GAP_M1;
    end
    if ((state_q == S_GAP) && !gap_done) gap_left_d = gap_left_q - 16'd1;

    if (load_first || load_next) flit_cnt_d = sat_inc(flit_cnt_d);

`ifdef INJECTOR_LFSR_EN
    sel_d    = accept ? pattern_sel : sel_q;
    lfsr_src = accept ? LFSR_SEED : lfsr_q;
    lfsr_adv = lfsr_step(lfsr_src);
    lfsr_d   = lfsr_q;
    if (accept) lfsr_d = LFSR_SEED;
    if (load_first || load_next) begin
      lfsr_d = lfsr_adv;
      word_d = sel_d ? lfsr_adv[W-1:0] : toggle_word;
    end
`else
    if (load_first || load_next) word_d = toggle_word;
`endif
  end

endmodule

// File: tb/tb_adder_flit_injector.sv
// Bench for adder_flit_injector: default-parameter instance plus a
// GAP=0/PAYLOAD=3/NUM_PKT=2 instance, compared cycle by cycle against a
// trace built from the packet/gap/done rules.
module tb_adder_flit_injector;

  localparam int N = 12;
  localparam logic [31:0] SEED = 32'hACE10001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, sel_a, start_b, sel_b;
  logic [N-1:0] in1_a, in2_a, in1_b, in2_b;
  logic valid_a, busy_a, done_a, valid_b, busy_b, done_b;
  logic [15:0] fcnt_a, pcnt_a, fcnt_b, pcnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  adder_flit_injector u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern_sel(sel_a),
    .input1(in1_a), .input2(in2_a), .valid(valid_a), .busy(busy_a), .done(done_a),
    .flit_cnt(fcnt_a), .pkt_cnt(pcnt_a)
  );

  adder_flit_injector #(.N(N), .PAYLOAD(3), .GAP(0), .NUM_PKT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern_sel(sel_b),
    .input1(in1_b), .input2(in2_b), .valid(valid_b), .busy(busy_b), .done(done_b),
    .flit_cnt(fcnt_b), .pkt_cnt(pcnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] obs(input int d);
    if (d == 0) return {valid_a, busy_a, done_a, in2_a, in1_a};
    return {valid_b, busy_b, done_b, in2_b, in1_b};
  endfunction

  function automatic logic [31:0] cnts(input int d);
    if (d == 0) return {fcnt_a, pcnt_a};
    return {fcnt_b, pcnt_b};
  endfunction

  task automatic drive(input int d, input logic s, input logic p);
    if (d == 0) begin start_a = s; sel_a = p; end
    else        begin start_b = s; sel_b = p; end
  endtask

  // Reference LFSR: XOR of the tapped bits (1-based tap numbers) fed in at bit 0.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic fb = 1'b0;
    foreach (taps[t]) fb ^= s[taps[t]-1];
    return {s[30:0], fb};
  endfunction

  // Expected per-cycle trace starting the cycle after the accept edge.
  task automatic build_exp(input int p, input int g, input int np, input bit use_lfsr,
                           output logic [26:0] q[$]);
    logic [23:0] w;
    logic [31:0] s;
    w = 24'h0;
    s = SEED;
    q = {};
    for (int k = 0; k < np; k++) begin
      for (int i = 0; i < p; i++) begin
        if (use_lfsr) begin
          s = model_step(s);
          w = s[23:0];
        end else begin
          w = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
        end
        q.push_back({3'b110, w});
      end
      for (int i = 0; i < g; i++) q.push_back({3'b010, w});
    end
    q.push_back({3'b001, w});
  endtask

  task automatic run(input int d, input bit sel, input bit noisy, input int abort_at,
                     input string tag);
    int p, g, np;
    bit use_lfsr;
    logic [26:0] q[$];
    logic [26:0] last;
    p  = (d == 0) ? 20 : 3;
    g  = (d == 0) ? 7 : 0;
    np = (d == 0) ? 10 : 2;
    use_lfsr = 1'b0;
`ifdef INJECTOR_LFSR_EN
    use_lfsr = sel;
`endif
    build_exp(p, g, np, use_lfsr, q);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    drive(d, 1'b1, sel);
    @(negedge clk);
    drive(d, 1'b0, 1'($urandom_range(0, 1)));
    for (int j = 0; j < q.size(); j++) begin
      chk(tag, 64'(obs(d)), 64'(q[j]));
      if (j == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_reset"}, {obs(d), cnts(d)}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {obs(d), cnts(d)}, 64'h0);
        return;
      end
      if (noisy) drive(d, (j == q.size() - 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
      if (j < q.size() - 1) @(negedge clk);
    end
    last = q[q.size() - 1];
    @(negedge clk);
    drive(d, 1'b0, 1'b0);
    chk({tag, "_after"}, 64'(obs(d)), {37'h0, 3'b000, last[23:0]});
    chk({tag, "_flit_cnt"}, 64'(cnts(d) >> 16), 64'(np * p));
    chk({tag, "_pkt_cnt"}, 64'(cnts(d) & 32'hFFFF), 64'(np));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_a", {obs(0), cnts(0)}, 64'h0);
    chk("reset_b", {obs(1), cnts(1)}, 64'h0);
    rst = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);

    run(0, 1'b0, 1'b0, -1, "tog_default");
    run(1, 1'b0, 1'b1, -1, "gap0");
    run(0, 1'b0, 1'b0, 20 + 7 + 4, "abort");
    run(0, 1'b0, 1'b1, -1, "rerun_noisy");
`ifdef INJECTOR_LFSR_EN
    run(0, 1'b1, 1'b0, -1, "lfsr_run1");
    run(0, 1'b1, 1'b0, -1, "lfsr_run2");
    run(1, 1'b1, 1'b1, -1, "lfsr_gap0");
`else
    run(0, 1'b1, 1'b0, -1, "sel_ignored");
    run(1, 1'b1, 1'b1, -1, "sel_ignored_gap0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_flit_injector.md
# adder_flit_injector

Synthesizable packet/flit stimulus source that drives the two operand buses of the `adder` under characterization. It emits NUM_PKT packets of PAYLOAD flits, separated by GAP idle cycles, so the adder sees a controlled injection rate and switching activity during power/energy runs. It sits directly upstream of `adder`: `input1`/`input2` connect straight to the adder's operand ports.

## Interface
- N, 12: adder operand width; one flit word is 2N bits (N ≤ 16).
- PAYLOAD, 20: flits per packet (≥ 1).
- GAP, 7: idle cycles after every packet (≥ 0).
- NUM_PKT, 10: packets per run (≥ 1).

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- pattern_sel  in  1  0 = toggle pattern, 1 = LFSR pattern (LFSR only when compiled in); sampled with start.
- input1  out  N  operand A = flit word[N-1:0], registered.
- input2  out  N  operand B = flit word[2N-1:N], registered.
- valid  out  1  high while a payload flit is presented.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- flit_cnt  out  16  flits emitted this run.
- pkt_cnt  out  16  packets completed this run.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: valid=0, busy=0. start=1 -> SEND; latch pattern_sel; clear counters; load first flit.
- SEND: one flit per cycle, valid=1. After the PAYLOAD-th flit of a packet: pkt_cnt+1; GAP>0 -> GAP, else if pkt_cnt reaches NUM_PKT -> DONE, else stay in SEND and load next packet's first flit.
- GAP: valid=0; input1/input2 hold the last flit; GAP cycles then SEND (next packet) or DONE (last packet).
- DONE: one cycle, done=1, busy=0, -> IDLE. Outputs keep last flit.
- Toggle pattern: word register starts all-zero at each packet start and inverts before each flit, so each packet emits all-ones, all-zero, all-ones, ... (flit 1 = all-ones). 100% toggle on every operand bit per flit.
- LFSR pattern: 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 32'hACE10001 reloaded on every accepted start; advances once per flit; flit word = LFSR[2N-1:0] after advance. Not reset between packets.
- start while busy: ignored. pattern_sel changes mid-run: ignored.
- flit_cnt/pkt_cnt saturate at 16'hFFFF; hold final values after DONE until next start.

## Timing
- Reset (rst=1 at an edge): state=IDLE; input1=0, input2=0, valid=0, busy=0, done=0, flit_cnt=0, pkt_cnt=0, LFSR=seed. Reset mid-run aborts immediately; no done pulse.
- Latency: start high at edge k -> first flit on input1/input2 with valid=1 after edge k; busy=1 from the same edge.
- Run length: valid is high for exactly NUM_PKT·PAYLOAD cycles; done pulses in cycle k+1+NUM_PKT·(PAYLOAD+GAP) after the accept edge k (gap included after last packet).
- start asserted in the DONE cycle: ignored; accepted in IDLE from the next cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- INJECTOR_LFSR_EN defined: LFSR generator present; pattern_sel=1 selects it.
- Not defined: LFSR logic removed; pattern_sel is ignored and the toggle pattern is always used; reset/seed behaviour irrelevant.

## Test plan
- Reset then start, pattern_sel=0, defaults -> flits FFF/FFF, 000/000 alternating, 20 valid cycles, 7 hold cycles, 10 packets; done at accept+1+270; flit_cnt=200, pkt_cnt=10.
- GAP=0, PAYLOAD=3, NUM_PKT=2 -> 6 consecutive valid cycles, each packet starting at FFF/FFF (FFF,000,FFF,FFF,000,FFF); done one cycle after last flit.
- rst asserted at flit 5 of packet 2 -> next cycle all outputs 0, IDLE, no done; fresh start reproduces the full sequence from flit 1.
- start pulsed repeatedly while busy and in DONE cycle -> single run, single done pulse, counters unchanged by extra starts.
- INJECTOR_LFSR_EN defined, pattern_sel=1 -> words match a bench LFSR model from seed 32'hACE10001; two consecutive runs produce identical sequences.
- INJECTOR_LFSR_EN undefined, pattern_sel=1 -> output identical to toggle-pattern run.
